// File: rtl/demux1x4_8bits_pkg.sv
// Shared definitions for the 4-lane receive de-serializer.
package demux1x4_8bits_pkg;
  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  localparam int LANES = 4;
  localparam int PH_W  = 2;
endpackage

// File: rtl/demux1x4_8bits_if.sv
// Serial input and parallel lane outputs of the 4-lane de-serializer.
interface demux1x4_8bits_if #(
  parameter int BW = 8
);
  logic [BW-1:0] data_000;
  logic          valid_000;
  logic [BW-1:0] data_0, data_1, data_2, data_3;
  logic          valid_0, valid_1, valid_2, valid_3;
  logic          frame_stb;
  logic          locked;

  modport master (
    output data_000, valid_000,
    input  data_0, data_1, data_2, data_3,
    input  valid_0, valid_1, valid_2, valid_3,
    input  frame_stb, locked
  );

  modport slave (
    input  data_000, valid_000,
    output data_0, data_1, data_2, data_3,
    output valid_0, valid_1, valid_2, valid_3,
    output frame_stb, locked
  );
endinterface

// File: rtl/demux1x4_8bits_lane_shadow.sv
// Enabled shadow register holding one lane's {valid, data} until frame load.
module lane_shadow #(
  parameter int W = 9
) (
  input  logic         clk_4f,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk_4f or negedge rst_n) begin
    if (!rst_n)  q <= '0;
    else if (en) q <= d;
  end
endmodule

// File: rtl/demux1x4_8bits.sv
// Receive de-serializer: one serial byte stream onto four parallel lanes.
//   state  | meaning
//   IDLE   | waiting for first valid byte, which becomes lane 0
//   LOCKED | phase free-runs; lane outputs load at phase 3
module demux1x4_8bits
  import demux1x4_8bits_pkg::*;
#(
  parameter int BW = 8
) (
  input  logic             clk_4f,
  input  logic             reset,
  demux1x4_8bits_if.slave  bus
);
  state_t          state, state_nx;
  logic [PH_W-1:0] ph, ph_nx;
  logic [LANES-2:0] shd_en;
  logic            load;
  logic [BW:0]     shd_q [LANES-1];

  always_ff @(posedge clk_4f or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      ph    <= '0;
    end else begin
      state <= state_nx;
      ph    <= ph_nx;
    end
  end

  always_comb begin
    state_nx = state;
    ph_nx    = ph;
    unique case (state)
      IDLE: begin
        if (bus.valid_000) begin
          state_nx = LOCKED;
          ph_nx    = 2'd1;
        end
      end
      LOCKED: ph_nx = ph + 2'd1;
      default: state_nx = IDLE;
    endcase
  end

  // In IDLE only a valid byte is taken, and always as lane 0.
  always_comb begin
    shd_en     = '0;
    load       = 1'b0;
    bus.locked = (state == LOCKED);
    unique case (state)
      IDLE: shd_en[0] = bus.valid_000;
      LOCKED: begin
        unique case (ph)
          2'd0:    shd_en[0] = 1'b1;
          2'd1:    shd_en[1] = 1'b1;
          2'd2:    shd_en[2] = 1'b1;
          default: load      = 1'b1;
        endcase
      end
      default: ;
    endcase
  end

  for (genvar k = 0; k < LANES - 1; k++) begin : g_shd
    lane_shadow #(.W(BW + 1)) u_shd (
      .clk_4f (clk_4f),
      .rst_n  (reset),
      .en     (shd_en[k]),
      .d      ({bus.valid_000, bus.data_000}),
      .q      (shd_q[k])
    );
  end

  // Lane 3 bypasses the shadows and goes straight into the output bank.
  always_ff @(posedge clk_4f or negedge reset) begin
    if (!reset) begin
      bus.data_0    <= '0;
      bus.data_1    <= '0;
      bus.data_2    <= '0;
      bus.data_3    <= '0;
      bus.valid_0   <= 1'b0;
      bus.valid_1   <= 1'b0;
      bus.valid_2   <= 1'b0;
      bus.valid_3   <= 1'b0;
      bus.frame_stb <= 1'b0;
    end else begin
      bus.frame_stb <= load;
      if (load) begin
        bus.data_0  <= shd_q[0][BW] ? shd_q[0][BW-1:0] : '0;
        bus.data_1  <= shd_q[1][BW] ? shd_q[1][BW-1:0] : '0;
        bus.data_2  <= shd_q[2][BW] ? shd_q[2][BW-1:0] : '0;
        bus.data_3  <= bus.valid_000 ? bus.data_000 : '0;
        bus.valid_0 <= shd_q[0][BW];
        bus.valid_1 <= shd_q[1][BW];
        bus.valid_2 <= shd_q[2][BW];
        bus.valid_3 <= bus.valid_000;
      end
    end
  end
endmodule

// File: tb/tb_demux1x4_8bits.sv
// Scoreboard bench for the 4-lane de-serializer.
module tb_demux1x4_8bits;
  logic clk_4f = 1'b0;
  logic reset  = 1'b0;
  always #5 clk_4f = ~clk_4f;

  demux1x4_8bits_if #(.BW(8)) bus ();
  demux1x4_8bits #(.BW(8)) dut (
    .clk_4f (clk_4f),
    .reset  (reset),
    .bus    (bus)
  );

  typedef struct {
    logic [31:0] d;
    logic [3:0]  v;
  } exp_t;

  exp_t sb [$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   epoch = 0;
  int   last_stb = -1;
  int   last_ep = -1;
  exp_t e;

  always @(posedge clk_4f) cyc <= cyc + 1;

  function automatic logic [31:0] lanes_d();
    return {bus.data_0, bus.data_1, bus.data_2, bus.data_3};
  endfunction

  function automatic logic [3:0] lanes_v();
    return {bus.valid_0, bus.valid_1, bus.valid_2, bus.valid_3};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic send(input logic [7:0] d, input logic v);
    @(negedge clk_4f);
    bus.data_000  = d;
    bus.valid_000 = v;
  endtask

  task automatic send_frame(input logic [31:0] d, input logic [3:0] v,
                            input logic [31:0] ed, input logic [3:0] ev);
    exp_t x;
    send(d[31:24], v[3]);
    send(d[23:16], v[2]);
    send(d[15:8],  v[1]);
    x.d = ed;
    x.v = ev;
    sb.push_back(x);
    send(d[7:0],   v[0]);
  endtask

  initial begin
    forever begin
      @(posedge clk_4f);
      #1;
      if (bus.frame_stb === 1'b1) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_stb: got frame_stb=1 expected no frame at t=%0t", $time);
        end else begin
          e = sb.pop_front();
          chk("lane_data", lanes_d(), e.d);
          chk("lane_valid", 32'(lanes_v()), 32'(e.v));
          chk("locked_at_stb", 32'(bus.locked), 32'd1);
        end
        if (last_stb >= 0 && last_ep == epoch) chk("stb_period", 32'(cyc - last_stb), 32'd4);
        last_stb = cyc;
        last_ep  = epoch;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.data_000  = '0;
    bus.valid_000 = 1'b0;
    #12;
    chk("rst_data", lanes_d(), 32'h0);
    chk("rst_valid", 32'(lanes_v()), 32'h0);
    chk("rst_locked", 32'(bus.locked), 32'h0);
    chk("rst_stb", 32'(bus.frame_stb), 32'h0);
    @(negedge clk_4f);
    reset = 1'b1;

    repeat (10) begin
      @(posedge clk_4f);
      #1;
      chk("idle_locked", 32'(bus.locked), 32'h0);
      chk("idle_data", lanes_d(), 32'h0);
    end

    send(8'h11, 1'b1);
    @(posedge clk_4f);
    #1;
    chk("lock_rise", 32'(bus.locked), 32'h1);
    send(8'h22, 1'b1);
    send(8'h33, 1'b1);
    e.d = 32'h11223344;
    e.v = 4'b1111;
    sb.push_back(e);
    send(8'h44, 1'b1);

    send_frame(32'hAABBCCDD, 4'b1010, 32'hAA00CC00, 4'b1010);
    send_frame(32'h01020304, 4'b1111, 32'h01020304, 4'b1111);
    send_frame(32'h05060708, 4'b1111, 32'h05060708, 4'b1111);
    send_frame(32'h090A0B0C, 4'b1111, 32'h090A0B0C, 4'b1111);
    send_frame(32'h55667788, 4'b0000, 32'h00000000, 4'b0000);

    send(8'h21, 1'b1);
    send(8'h22, 1'b1);
    @(posedge clk_4f);
    #2;
    reset         = 1'b0;
    bus.valid_000 = 1'b0;
    epoch++;
    #1;
    chk("mid_rst_data", lanes_d(), 32'h0);
    chk("mid_rst_valid", 32'(lanes_v()), 32'h0);
    chk("mid_rst_locked", 32'(bus.locked), 32'h0);
    chk("mid_rst_stb", 32'(bus.frame_stb), 32'h0);
    @(negedge clk_4f);
    @(negedge clk_4f);
    reset = 1'b1;

    send(8'hFF, 1'b0);
    send(8'hFF, 1'b0);
    @(posedge clk_4f);
    #1;
    chk("relock_wait", 32'(bus.locked), 32'h0);
    send_frame(32'h31323334, 4'b1111, 32'h31323334, 4'b1111);

    repeat (3) begin
      send(8'hEE, 1'b0);
      @(posedge clk_4f);
      #1;
      chk("hold_data", lanes_d(), 32'h31323334);
      chk("hold_valid", 32'(lanes_v()), 32'h0000000F);
    end

    chk("sb_empty", 32'(sb.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/demux1x4_8bits.md
# demux1x4_8bits

Receive-side de-serializer for the 4-lane byte link. It takes the single 8-bit serial stream produced by the transmit mux chain at the 4f rate and redistributes it onto four parallel 8-bit lanes, each with its own valid flag. The four lanes are updated once per 4-byte frame. The block runs entirely in the `clk_4f` domain and sits at the receive end of the link, ahead of the per-lane flop stages.

## Interface
Parameters:
- `BW`, default 8, data width per lane and of the serial input.

Ports:
- `clk_4f`  in  1  serial byte clock; all state is updated on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `data_000`  in  BW  serial input byte.
- `valid_000`  in  1  serial input byte is valid.
- `data_0`, `data_1`, `data_2`, `data_3`  out  BW each  de-serialized lane data.
- `valid_0`, `valid_1`, `valid_2`, `valid_3`  out  1 each  lane valid flags.
- `frame_stb`  out  1  one-cycle pulse on the cycle the lane outputs change.
- `locked`  out  1  frame alignment has been acquired.

## Operation
- Frame order on the serial line is fixed: lane 0, lane 1, lane 2, lane 3, repeating.
- The FSM has two states: IDLE and LOCKED.
  - IDLE: a 2-bit phase counter `ph` is held at 0. Bytes with `valid_000`=0 are ignored. The first byte with `valid_000`=1 is captured as lane 0, then `ph`←1 and the state moves to LOCKED.
  - LOCKED: `ph` free-runs modulo 4 (3→0 wrap). The byte and valid flag at phase k are captured into shadow register k, whatever the value of `valid_000`. The block never returns to IDLE except through reset.
- At `ph`==3 (lane 3 capture), the same edge loads all four output lanes: shadow 0–2 plus the incoming lane-3 byte and valid. `frame_stb` is 1 for that cycle.
- Invalid lanes produce zero data: if a lane's captured valid is 0, its `data_k` output is 0.
- Outputs hold between frames. A frame with all four bytes invalid still updates the outputs (all valids 0, all data 0) and still pulses `frame_stb`.
- `locked` = (state==LOCKED).

## Timing
- Reset (asynchronous, `reset`=0) sets:
  - all `data_k`=0, all `valid_k`=0, `frame_stb`=0, `locked`=0;
  - `ph`=0, shadows=0, state=IDLE.
- The first edge after `reset` rises is a normal capture edge.
- Latency: a lane-0 byte sampled at edge t appears on `data_0` after edge t+3. The lane-3 byte appears after the same edge it is sampled on, i.e. it is registered directly to the output.
- `frame_stb` is asserted in the cycle after each output update edge, exactly once every 4 cycles while LOCKED.
- `locked` rises after the edge that captures the first valid byte.
- Reset asserted mid-frame discards the partial frame. Outputs clear immediately (asynchronously). Re-lock waits for the next valid byte.
- The output update and the phase wrap happen on the same edge. There is no bubble between consecutive frames.

## Structure
- Shared package: the FSM state encoding (IDLE=0, LOCKED=1), the lane count constant (4), and the phase width (2).
- One natural sub-module, `lane_shadow`: a BW+1-bit enabled register with asynchronous active-low clear, instantiated once per lane for lanes 0–2.
- The top level holds the FSM, the phase counter, the output register bank, and the zero-on-invalid gating.

## Test plan
- Reset release with `valid_000`=0 held for 10 cycles -> `locked`=0, all outputs 0, no `frame_stb`.
- Serial input 0x11,0x22,0x33,0x44, all valid -> after the 4th edge: `data_0..3`=0x11,0x22,0x33,0x44, all `valid_k`=1, `frame_stb` for 1 cycle, `locked`=1.
- Serial input 0xAA(v),0xBB(inv),0xCC(v),0xDD(inv) -> `data_0`=0xAA, `data_1`=0, `data_2`=0xCC, `data_3`=0, `valid`=1,0,1,0.
- Three back-to-back frames 0x01..0x04, 0x05..0x08, 0x09..0x0C -> outputs change on edges 4, 8 and 12 with the matching values, and `frame_stb` is periodic every 4 cycles.
- `reset` asserted after the 2nd byte of frame 2 -> outputs clear immediately. Frame 3 after release locks on its first valid byte and produces correct lanes.
- A locked link sends one all-invalid frame -> all valids 0, data 0, `frame_stb` still pulses, `locked` stays 1.
